// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the sum accumulator stage.
`default_nettype none
`timescale 1ns/1ps

package sum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_ACC_W     = 40;
  localparam int DEF_MAX_BEATS = 16;

  // Counter must represent 1..max_beats inclusive.
  function automatic int beat_cnt_w(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sum_accumulator_if.sv
// Beat input and result output channels of the sum accumulator.
`default_nettype none
`timescale 1ns/1ps

interface sum_accumulator_if
  import sum_acc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS
);
  localparam int BW = beat_cnt_w(MAX_BEATS);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_cout;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [BW-1:0]    out_beats;
  logic             out_ovf;

  modport master (
    output in_valid, in_sum, in_cout, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_beats, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, in_cout, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_beats, out_ovf
  );

endinterface

`default_nettype wire

// File: rtl/sum_acc_add.sv
// Accumulator adder with carry-out detect; SUM_ACC_SAT_EN selects clamping instead of wrapping.
`default_nettype none
`timescale 1ns/1ps

module sum_acc_add #(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] beat,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W:0] raw;

  assign raw = {1'b0, acc} + {1'b0, beat};
  assign ovf = raw[ACC_W];

`ifdef SUM_ACC_SAT_EN
  // Once clamped, any later non-zero beat overflows again, so the clamp persists.
  assign sum = ovf ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
  assign sum = raw[ACC_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/sum_accumulator.sv
// Burst accumulator for {Cout,Sum} adder beats; one registered total per burst.
// Optional saturation via SUM_ACC_SAT_EN (see sum_acc_add).
`default_nettype none
`timescale 1ns/1ps

module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic               clk,
  input  logic               rst_n,
  sum_accumulator_if.slave   bus
);

  localparam int BW = beat_cnt_w(MAX_BEATS);

  state_t           state;
  state_t           state_nxt;
  logic             ready_r;
  logic             ready_nxt;
  logic             valid_r;
  logic             valid_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [BW-1:0]    beats;
  logic [BW-1:0]    beats_nxt;
  logic             ovf;
  logic             ovf_nxt;
  logic [ACC_W-1:0] beat;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             fire;

  assign beat = ACC_W'({bus.in_cout, bus.in_sum});
  assign fire = bus.in_valid & ready_r;

  sum_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc  (acc),
    .beat (beat),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (fire) state_nxt = (bus.in_last || MAX_BEATS == 1) ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (fire && (bus.in_last || beats == BW'(MAX_BEATS - 1))) state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they never see in_valid/out_ready combinationally.
  always_comb begin
    ready_nxt = (state_nxt != HOLD);
    valid_nxt = (state_nxt == HOLD);
    acc_nxt   = acc;
    beats_nxt = beats;
    ovf_nxt   = ovf;
    if (fire && state == IDLE) begin
      acc_nxt   = beat;
      beats_nxt = BW'(1);
      ovf_nxt   = 1'b0;
    end else if (fire && state == ACCUM) begin
      acc_nxt   = add_sum;
      beats_nxt = beats + BW'(1);
      ovf_nxt   = ovf | add_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      acc     <= '0;
      beats   <= '0;
      ovf     <= 1'b0;
    end else begin
      ready_r <= ready_nxt;
      valid_r <= valid_nxt;
      acc     <= acc_nxt;
      beats   <= beats_nxt;
      ovf     <= ovf_nxt;
    end
  end

  assign bus.in_ready  = ready_r;
  assign bus.out_valid = valid_r;
  assign bus.out_acc   = acc;
  assign bus.out_beats = beats;
  assign bus.out_ovf   = ovf;

endmodule

`default_nettype wire

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: 16-beat instance for burst scenarios, 256-beat instance for overflow.
`default_nettype none
`timescale 1ns/1ps

module tb_sum_accumulator;
  import sum_acc_pkg::*;

  typedef struct {
    logic [39:0] acc;
    logic [4:0]  beats;
    logic        ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  exp_t        q[$];
  logic [39:0] m_acc   = '0;
  int          m_beats = 0;
  logic        m_ovf   = 1'b0;

  always #5 clk = ~clk;

  sum_accumulator_if #(.WIDTH(32), .ACC_W(40), .MAX_BEATS(16))  bus_a ();
  sum_accumulator_if #(.WIDTH(32), .ACC_W(40), .MAX_BEATS(256)) bus_b ();

  sum_accumulator #(.WIDTH(32), .ACC_W(40), .MAX_BEATS(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  sum_accumulator #(.WIDTH(32), .ACC_W(40), .MAX_BEATS(256)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // Called at a negedge; returns at the negedge after the beat transferred. Updates the model.
  task automatic push_a(input logic [31:0] s, input logic c, input logic l);
    int n;
    logic [40:0] w;
    logic [39:0] bv;
    exp_t e;
    n = 0;
    bus_a.in_valid = 1'b1; bus_a.in_sum = s; bus_a.in_cout = c; bus_a.in_last = l;
    while (!bus_a.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; fails++;
      $display("FAIL push_a timeout: in_ready=%b required 1", bus_a.in_ready);
    end
    @(negedge clk);
    bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
    bv = {7'd0, c, s};
    if (m_beats == 0) begin
      m_acc = bv; m_ovf = 1'b0;
    end else begin
      w = {1'b0, m_acc} + {1'b0, bv};
      if (w[40]) m_ovf = 1'b1;
`ifdef SUM_ACC_SAT_EN
      m_acc = w[40] ? 40'hFF_FFFF_FFFF : w[39:0];
`else
      m_acc = w[39:0];
`endif
    end
    m_beats++;
    if (l || m_beats == 16) begin
      e.acc = m_acc; e.beats = 5'(m_beats); e.ovf = m_ovf;
      q.push_back(e);
      m_beats = 0;
    end
  endtask

  task automatic drain_a(input string name);
    int n;
    exp_t e;
    n = 0;
    while (!bus_a.out_valid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!bus_a.out_valid || q.size() == 0) begin
      fails++;
      $display("FAIL %s result: out_valid=%b queued=%0d required valid with 1 queued", name, bus_a.out_valid, q.size());
    end else begin
      e = q.pop_front();
      checks += 2;
      if (bus_a.out_acc !== e.acc) begin
        fails++; $display("FAIL %s acc: got %h required %h", name, bus_a.out_acc, e.acc);
      end
      if (bus_a.out_beats !== e.beats) begin
        fails++; $display("FAIL %s beats: got %0d required %0d", name, bus_a.out_beats, e.beats);
      end
      checks++;
      if (bus_a.out_ovf !== e.ovf) begin
        fails++; $display("FAIL %s ovf: got %b required %b", name, bus_a.out_ovf, e.ovf);
      end
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus_a.in_ready !== 1'b0)  begin fails++; $display("FAIL reset in_ready: got %b required 0", bus_a.in_ready); end
    if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b required 0", bus_a.out_valid); end
    if (bus_a.out_acc !== 40'd0)  begin fails++; $display("FAIL reset out_acc: got %h required 0", bus_a.out_acc); end
    if (bus_a.out_beats !== 5'd0) begin fails++; $display("FAIL reset out_beats: got %0d required 0", bus_a.out_beats); end
    if (bus_a.out_ovf !== 1'b0)   begin fails++; $display("FAIL reset out_ovf: got %b required 0", bus_a.out_ovf); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL post-reset in_ready: got %b required 1", bus_a.in_ready); end
  endtask

  task automatic test_single();
    push_a(32'h5, 1'b0, 1'b1);
    checks++;
    if (bus_a.out_valid !== 1'b1) begin fails++; $display("FAIL single latency: out_valid=%b required 1", bus_a.out_valid); end
    checks++;
    if (bus_a.out_acc !== 40'd5) begin fails++; $display("FAIL single const acc: got %h required 5", bus_a.out_acc); end
    drain_a("single");
  endtask

  task automatic test_burst3();
    push_a(32'h5, 1'b0, 1'b0);
    push_a(32'h5, 1'b0, 1'b0);
    push_a(32'h5, 1'b0, 1'b1);
    checks++;
    if (bus_a.out_acc !== 40'd15) begin fails++; $display("FAIL burst3 const acc: got %h required f", bus_a.out_acc); end
    drain_a("burst3");
  endtask

  task automatic test_autoclose();
    for (int i = 0; i < 16; i++) push_a(32'hFFFF_FFFF, 1'b1, 1'b0);
    checks += 3;
    if (bus_a.out_valid !== 1'b1) begin fails++; $display("FAIL autoclose valid: got %b required 1", bus_a.out_valid); end
    if (bus_a.in_ready !== 1'b0)  begin fails++; $display("FAIL autoclose in_ready: got %b required 0", bus_a.in_ready); end
    if (bus_a.out_acc !== 40'h1F_FFFF_FFF0) begin
      fails++; $display("FAIL autoclose const acc: got %h required 1ffffffff0", bus_a.out_acc);
    end
    drain_a("autoclose");
  endtask

  task automatic test_backpressure();
    push_a(32'h7, 1'b0, 1'b1);
    bus_a.in_valid = 1'b1; bus_a.in_sum = 32'h9; bus_a.in_cout = 1'b0; bus_a.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 4;
      if (bus_a.in_ready !== 1'b0)  begin fails++; $display("FAIL bp in_ready c%0d: got %b required 0", i, bus_a.in_ready); end
      if (bus_a.out_valid !== 1'b1) begin fails++; $display("FAIL bp out_valid c%0d: got %b required 1", i, bus_a.out_valid); end
      if (bus_a.out_acc !== q[0].acc) begin fails++; $display("FAIL bp acc c%0d: got %h required %h", i, bus_a.out_acc, q[0].acc); end
      if (bus_a.out_beats !== q[0].beats) begin
        fails++; $display("FAIL bp beats c%0d: got %0d required %0d", i, bus_a.out_beats, q[0].beats);
      end
    end
    drain_a("bp_first");
    push_a(32'h9, 1'b0, 1'b1);
    drain_a("bp_held_beat");
  endtask

  task automatic test_back_to_back();
    int lens[2] = '{3, 5};
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < lens[b]; i++)
        push_a($urandom, 1'($urandom_range(0, 1)), i == lens[b] - 1);
      drain_a("b2b");
    end
  endtask

  task automatic test_reset_mid();
    push_a(32'h1, 1'b0, 1'b0);
    push_a(32'h2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL midrst out_valid: got %b required 0", bus_a.out_valid); end
    if (bus_a.out_acc !== 40'd0)  begin fails++; $display("FAIL midrst out_acc: got %h required 0", bus_a.out_acc); end
    if (bus_a.out_beats !== 5'd0) begin fails++; $display("FAIL midrst out_beats: got %0d required 0", bus_a.out_beats); end
    if (bus_a.in_ready !== 1'b0)  begin fails++; $display("FAIL midrst in_ready: got %b required 0", bus_a.in_ready); end
    m_beats = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_a(32'h3, 1'b0, 1'b1);
    drain_a("after_midrst");
  endtask

  task automatic test_overflow();
    int n;
    longint unsigned full;
    logic [39:0] exp_acc;
    full = 64'd200 * ((64'd1 << 33) - 64'd1);
`ifdef SUM_ACC_SAT_EN
    exp_acc = 40'hFF_FFFF_FFFF;
`else
    exp_acc = full[39:0];
`endif
    for (int i = 0; i < 200; i++) begin
      bus_b.in_valid = 1'b1; bus_b.in_sum = 32'hFFFF_FFFF; bus_b.in_cout = 1'b1; bus_b.in_last = (i == 199);
      n = 0;
      while (!bus_b.in_ready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin checks++; fails++; $display("FAIL ovf timeout beat %0d: in_ready=0 required 1", i); end
      @(negedge clk);
    end
    bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
    checks += 4;
    if (bus_b.out_valid !== 1'b1)  begin fails++; $display("FAIL ovf valid: got %b required 1", bus_b.out_valid); end
    if (bus_b.out_acc !== exp_acc) begin fails++; $display("FAIL ovf acc: got %h required %h", bus_b.out_acc, exp_acc); end
    if (bus_b.out_beats !== 9'd200) begin fails++; $display("FAIL ovf beats: got %0d required 200", bus_b.out_beats); end
    if (bus_b.out_ovf !== 1'b1)    begin fails++; $display("FAIL ovf flag: got %b required 1", bus_b.out_ovf); end
    bus_b.out_ready = 1'b1;
    @(negedge clk);
    bus_b.out_ready = 1'b0;
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_sum = '0; bus_a.in_cout = 1'b0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_sum = '0; bus_b.in_cout = 1'b0; bus_b.in_last = 1'b0; bus_b.out_ready = 1'b0;
    test_reset();
    test_single();
    test_burst3();
    test_autoclose();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
